seg7_scan_driver: RTL and testbench
===================================

SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 The block SHALL take parameter NUM_DIGITS, default 4: number of multiplexed digits, legal range 1..8.
REQ-002 The block SHALL take parameter REFRESH_DIV, default 50000: clock cycles per digit slot, minimum 4.
REQ-003 The block SHALL take parameter BLANK_CYCLES, default 2: anode-off guard cycles at the end of each slot, legal range 0..REFRESH_DIV-1.
REQ-004 The block SHALL take parameter ACTIVE_LOW, default 1: when 1, seg, dp and an are inverted at the pins.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-006 The block SHALL have port reset, input, 1 bit: reset, synchronous and active-high.
REQ-007 The block SHALL have port enable, input, 1 bit: scan enable.
REQ-008 The block SHALL have port load, input, 1 bit: single-cycle strobe that captures value and dp_in.
REQ-009 The block SHALL have port value, input, 4*NUM_DIGITS bits: hex nibbles, with digit 0 in bits [3:0].
REQ-010 The block SHALL have port dp_in, input, NUM_DIGITS bits: per-digit decimal point request.
REQ-011 The block SHALL have port lz_en, input, 1 bit: leading-zero suppression enable.
REQ-012 The block SHALL have port seg, output, 7 bits: segments {a,b,c,d,e,f,g}, with a as the MSB.
REQ-013 The block SHALL have port dp, output, 1 bit: decimal-point segment.
REQ-014 The block SHALL have port an, output, NUM_DIGITS bits: digit anodes, one-hot while lit.
REQ-015 The block SHALL have port pending, output, 1 bit: high while a loaded value awaits commit.

Function
REQ-016 The block SHALL compute all logic internally as active-high, applying the ACTIVE_LOW inversion only at the output registers.
REQ-017 The block SHALL use this internal segment encoding: 0=7E, 1=30, 2=6D, 3=79, 4=33, 5=5B, 6=5F, 7=70, 8=7F, 9=7B, A=77, b=1F, C=4E, d=3D, E=4F, F=47.
REQ-018 The block SHALL implement two states: IDLE and SCAN.
REQ-019 In IDLE, the block SHALL hold all outputs inactive, the slot counter at 0 and the digit index at 0.
REQ-020 IDLE SHALL go to SCAN on the cycle after enable is sampled high.
REQ-021 SCAN SHALL go to IDLE on the cycle after enable is sampled low, with outputs inactive and the counter and index cleared in that same cycle.
REQ-022 In SCAN, the slot counter SHALL run 0..REFRESH_DIV-1 and then wrap to 0; on each wrap the digit index SHALL increment, wrapping from NUM_DIGITS-1 to 0.
REQ-023 The slot counter width SHALL be clog2(REFRESH_DIV), and the digit index width SHALL be max(1, clog2(NUM_DIGITS)).
REQ-024 While counter < REFRESH_DIV-BLANK_CYCLES, the block SHALL assert an[index] only, with seg and dp showing the digit at index.
REQ-025 During the last BLANK_CYCLES cycles of each slot, the block SHALL drive an, seg and dp all inactive.
REQ-026 Outputs SHALL be registered: the output state for slot position k SHALL appear one cycle after the counter equals k.
REQ-027 The block SHALL display from a committed register (nibbles plus dp bits); the pending register SHALL hold the last load.
REQ-028 A load SHALL capture value and dp_in into the pending register and set pending on the next edge.
REQ-029 A load while pending is already high SHALL overwrite the pending register, leaving only the last load effective.
REQ-030 Commit SHALL occur on the edge where the index wraps from NUM_DIGITS-1 to 0 (frame boundary): pending is copied to committed and pending clears.
REQ-031 If load is asserted in the same cycle as a frame boundary, the block SHALL commit the incoming value directly and leave pending low.
REQ-032 In IDLE, a load SHALL commit on the next edge without waiting, and pending SHALL not be set.
REQ-033 When lz_en is high, the block SHALL blank zero-valued digits from digit NUM_DIGITS-1 downward until the first nonzero digit, using committed data.
REQ-034 Digit 0 SHALL never be suppressed.
REQ-035 A blanked digit's dp SHALL still follow its committed dp bit.
REQ-036 When lz_en is low, the block SHALL display every digit.

Reset
REQ-037 Reset SHALL take priority over all other inputs, including load and enable.
REQ-038 On reset, the block SHALL enter IDLE with counter 0, index 0, committed and pending registers 0, and pending 0.
REQ-039 On reset, seg, dp and an SHALL be inactive at pin polarity: all ones when ACTIVE_LOW=1, all zeros when ACTIVE_LOW=0.
REQ-040 A reset asserted mid-scan or mid-pending SHALL discard the pending data.

Verification
REQ-041 Bench SHALL cover: NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2, ACTIVE_LOW=0, load value=16'h12AF in IDLE, then enable -> an sequence 0001, 0010, 0100, 1000, each lit 6 cycles then off 2 cycles; seg sequence 47, 77, 6D, 30.
REQ-042 Bench SHALL cover: mid-frame load of 16'h0000 while displaying 16'h12AF -> pending=1 until the index wraps 3->0; old digits keep being shown until then; digit 0 then shows 7E.
REQ-043 Bench SHALL cover: lz_en=1 with committed value 16'h0050 -> digits 3 and 2 blanked (seg 00, an still stepping); digit 1 shows 5B; digit 0 shows 7E.
REQ-044 Bench SHALL cover: committed 16'h0000, lz_en=1 -> only digit 0 lit, showing 7E; dp_in=4'b1000 -> dp high in digit 3's slot with seg 00.
REQ-045 Bench SHALL cover: ACTIVE_LOW=1, enable dropped mid-slot -> next cycle seg=7F, dp=1, an=1111; re-enable -> restart at digit 0, counter 0.
REQ-046 Bench SHALL cover: reset asserted with pending=1 and load high in the same cycle -> pending=0, committed=0, outputs inactive on the next edge.

Source files
------------

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed seven-segment driver: scans NUM_DIGITS anodes with a blanking guard,
// double-buffers the displayed value so updates land on frame boundaries, and suppresses leading zeros.
module seg7_scan_driver #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 2,
  parameter bit ACTIVE_LOW   = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    lz_en,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    pending
);

  localparam int CW      = $clog2(REFRESH_DIV);
  localparam int IW      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int LIT_END = REFRESH_DIV - BLANK_CYCLES;
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

  typedef enum logic {IDLE, SCAN} state_e;

  state_e                  state_q;
  logic [CW-1:0]           cnt_q;
  logic [IW-1:0]           idx_q;
  logic [4*NUM_DIGITS-1:0] com_val_q, pend_val_q;
  logic [NUM_DIGITS-1:0]   com_dp_q, pend_dp_q;
  logic                    pending_q;
  logic [6:0]              seg_q;
  logic                    dp_q;
  logic [NUM_DIGITS-1:0]   an_q;

  logic [NUM_DIGITS-1:0]   lz_blank;
  logic                    lit, frame_end;
  logic [3:0]              cur_nib;
  logic [6:0]              seg_d;
  logic                    dp_d;
  logic [NUM_DIGITS-1:0]   an_d;

  function automatic logic [6:0] seg7_font(input logic [3:0] nib);
    case (nib)
      4'h0: return 7'h7E;
      4'h1: return 7'h30;
      4'h2: return 7'h6D;
      4'h3: return 7'h79;
      4'h4: return 7'h33;
      4'h5: return 7'h5B;
      4'h6: return 7'h5F;
      4'h7: return 7'h70;
      4'h8: return 7'h7F;
      4'h9: return 7'h7B;
      4'hA: return 7'h77;
      4'hB: return 7'h1F;
      4'hC: return 7'h4E;
      4'hD: return 7'h3D;
      4'hE: return 7'h4F;
      default: return 7'h47;
    endcase
  endfunction

  // A digit is blanked when it and every digit above it are zero; digit 0 is never blanked.
  always_comb begin
    logic zeros_above;
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (latch).
    lz_blank    = '0;
    zeros_above = 1'b1;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      zeros_above = zeros_above && (com_val_q[4*i +: 4] == 4'h0);
      lz_blank[i] = zeros_above;
    end
  end

  always_comb begin
    lit       = (state_q == SCAN) && enable && (int'(cnt_q) < LIT_END);
    frame_end = (state_q == SCAN) && enable && (cnt_q == CNT_LAST) && (idx_q == IDX_LAST);
    cur_nib   = com_val_q[4*idx_q +: 4];
    seg_d     = 7'h00;
    dp_d      = 1'b0;
    an_d      = '0;
    if (lit) begin
      seg_d = (lz_en && lz_blank[idx_q]) ? 7'h00 : seg7_font(cur_nib);
      dp_d  = com_dp_q[idx_q];
      an_d  = NUM_DIGITS'(1) << idx_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      state_q    <= IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      com_val_q  <= '0;
      com_dp_q   <= '0;
      pend_val_q <= '0;
      pend_dp_q  <= '0;
      pending_q  <= 1'b0;
      seg_q      <= {7{ACTIVE_LOW}};
      dp_q       <= ACTIVE_LOW;
      an_q       <= {NUM_DIGITS{ACTIVE_LOW}};
    end else begin
      seg_q <= seg_d ^ {7{ACTIVE_LOW}};
      dp_q  <= dp_d ^ ACTIVE_LOW;
      an_q  <= an_d ^ {NUM_DIGITS{ACTIVE_LOW}};

      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          idx_q <= '0;
          if (enable) state_q <= SCAN;
        end
        SCAN: begin
          if (!enable) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
          end else if (cnt_q == CNT_LAST) begin
            cnt_q <= '0;
            idx_q <= (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase

      if (load) begin
        pend_val_q <= value;
        pend_dp_q  <= dp_in;
      end

      // Loads bypass the pending buffer when idle or exactly on a frame boundary.
      if (load && (state_q == IDLE || frame_end)) begin
        com_val_q <= value;
        com_dp_q  <= dp_in;
        pending_q <= 1'b0;
      end else if (frame_end && pending_q) begin
        com_val_q <= pend_val_q;
        com_dp_q  <= pend_dp_q;
        pending_q <= 1'b0;
      end else if (load) begin
        pending_q <= 1'b1;
      end
    end
  end

  assign seg     = seg_q;
  assign dp      = dp_q;
  assign an      = an_q;
  assign pending = pending_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Randomized and directed bench for seg7_scan_driver: one active-high and one active-low instance
// share stimulus and are compared every cycle against a scan-position reference model.
module tb_seg7_scan_driver;

  localparam int ND = 4;
  localparam int RD = 8;
  localparam int BC = 2;
  localparam int FRAME = RD * ND;

  logic        clk = 1'b0;
  logic        reset, enable, load, lz_en;
  logic [15:0] value;
  logic [3:0]  dp_in;

  logic [6:0]  seg0, seg1;
  logic        dp0, dp1, pend0, pend1;
  logic [3:0]  an0, an1;

  int checks = 0;
  int errors = 0;

  // Reference model state: m_t counts cycles since the scan started.
  logic        m_scan = 1'b0;
  int          m_t = 0;
  logic [15:0] m_com_val = '0, m_pend_val = '0;
  logic [3:0]  m_com_dp = '0, m_pend_dp = '0;
  logic        m_pending = 1'b0;
  logic [6:0]  m_seg, m_seg_al;
  logic        m_dp, m_dp_al;
  logic [3:0]  m_an, m_an_al;

  logic [6:0] font [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                            7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

  seg7_scan_driver #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .BLANK_CYCLES(BC), .ACTIVE_LOW(1'b0)) u_dut_ah (
    .clk(clk), .reset(reset), .enable(enable), .load(load), .value(value), .dp_in(dp_in),
    .lz_en(lz_en), .seg(seg0), .dp(dp0), .an(an0), .pending(pend0)
  );

  seg7_scan_driver #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .BLANK_CYCLES(BC), .ACTIVE_LOW(1'b1)) u_dut_al (
    .clk(clk), .reset(reset), .enable(enable), .load(load), .value(value), .dp_in(dp_in),
    .lz_en(lz_en), .seg(seg1), .dp(dp1), .an(an1), .pending(pend1)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advances the model across one clock edge using the inputs held before the edge.
  task automatic model_edge();
    int   pos, dig, hi;
    logic boundary;
    if (reset) begin
      m_scan = 1'b0; m_t = 0;
      m_com_val = '0; m_com_dp = '0; m_pend_val = '0; m_pend_dp = '0; m_pending = 1'b0;
      m_seg = '0; m_dp = 1'b0; m_an = '0;
    end else begin
      m_seg = '0; m_dp = 1'b0; m_an = '0;
      if (m_scan && enable) begin
        pos = m_t % RD;
        dig = (m_t / RD) % ND;
        if (pos < RD - BC) begin
          hi = 0;
          for (int d = 0; d < ND; d++) if (m_com_val[4*d +: 4] != 4'h0) hi = d;
          m_an  = 4'(1 << dig);
          m_seg = (lz_en && dig > hi) ? 7'h00 : font[m_com_val[4*dig +: 4]];
          m_dp  = m_com_dp[dig];
        end
      end
      boundary = m_scan && enable && (m_t % FRAME == FRAME - 1);
      if (load && (!m_scan || boundary)) begin
        m_com_val = value; m_com_dp = dp_in; m_pending = 1'b0;
      end else if (boundary && m_pending) begin
        m_com_val = m_pend_val; m_com_dp = m_pend_dp; m_pending = 1'b0;
      end else if (load) begin
        m_pending = 1'b1;
      end
      if (load) begin
        m_pend_val = value; m_pend_dp = dp_in;
      end
      if (m_scan && enable) m_t++;
      else m_t = 0;
      m_scan = enable;
    end
    m_seg_al = ~m_seg;
    m_dp_al  = ~m_dp;
    m_an_al  = ~m_an;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("seg", seg0, m_seg);
    check("dp", dp0, m_dp);
    check("an", an0, m_an);
    check("pending", pend0, m_pending);
    check("seg_al", seg1, m_seg_al);
    check("dp_al", dp1, m_dp_al);
    check("an_al", an1, m_an_al);
    check("pending_al", pend1, m_pending);
  endtask

  // Steps until the outputs show position 0 of digit 0, bounded.
  task automatic wait_digit0();
    int n = 0;
    do begin
      step();
      n++;
    end while (!(m_scan && (m_t % FRAME == 1)) && n < 200);
    if (n >= 200) check("wait_digit0_timeout", n, 0);
  endtask

  logic [6:0] seq41 [4] = '{7'h47, 7'h77, 7'h6D, 7'h30};

  initial begin
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    reset = 1'b1; enable = 1'b0; load = 1'b0; value = '0; dp_in = '0; lz_en = 1'b0;
    step(); step();
    check("rst_an_al", an1, 4'hF);
    check("rst_seg_al", seg1, 7'h7F);
    check("rst_an_ah", an0, 4'h0);
    reset = 1'b0;

    // 12AF loaded while idle, then one full frame.
    load = 1'b1; value = 16'h12AF; step(); load = 1'b0;
    check("idle_load_no_pending", pend0, 1'b0);
    enable = 1'b1; step();
    for (int s = 0; s < FRAME; s++) begin
      step();
      exp_an  = (s % RD < RD - BC) ? 4'(1 << (s / RD)) : 4'h0;
      exp_seg = (s % RD < RD - BC) ? seq41[s / RD] : 7'h00;
      check("frame_an", an0, exp_an);
      check("frame_seg", seg0, exp_seg);
    end

    // Mid-frame load of 0000 waits for the frame boundary.
    repeat (10) step();
    load = 1'b1; value = 16'h0000; step(); load = 1'b0;
    check("midframe_pending", pend0, 1'b1);
    repeat (4) step();
    check("still_pending", pend0, 1'b1);
    wait_digit0();
    check("commit_pending_clr", pend0, 1'b0);
    check("commit_d0_seg", seg0, 7'h7E);

    // Leading-zero suppression with 0050.
    lz_en = 1'b1;
    load = 1'b1; value = 16'h0050; step(); load = 1'b0;
    wait_digit0();
    check("lz_d0_seg", seg0, 7'h7E);
    repeat (RD) step();
    check("lz_d1_seg", seg0, 7'h5B);
    check("lz_d1_an", an0, 4'b0010);
    repeat (RD) step();
    check("lz_d2_seg", seg0, 7'h00);
    check("lz_d2_an", an0, 4'b0100);
    repeat (RD) step();
    check("lz_d3_seg", seg0, 7'h00);
    check("lz_d3_an", an0, 4'b1000);

    // All-zero value: only digit 0 shows a glyph; a blanked digit keeps its dp.
    load = 1'b1; value = 16'h0000; dp_in = 4'b1000; step(); load = 1'b0; dp_in = 4'b0000;
    wait_digit0();
    check("zero_d0_seg", seg0, 7'h7E);
    check("zero_d0_dp", dp0, 1'b0);
    repeat (RD) step();
    check("zero_d1_seg", seg0, 7'h00);
    repeat (2 * RD) step();
    check("zero_d3_seg", seg0, 7'h00);
    check("zero_d3_dp", dp0, 1'b1);
    check("zero_d3_an", an0, 4'b1000);

    // Enable dropped mid-slot, then re-enabled.
    repeat (3) step();
    enable = 1'b0; step();
    check("dis_seg_al", seg1, 7'h7F);
    check("dis_dp_al", dp1, 1'b1);
    check("dis_an_al", an1, 4'hF);
    step();
    check("idle_an_al", an1, 4'hF);
    enable = 1'b1; step(); step();
    check("reen_an_al", an1, 4'b1110);
    check("reen_seg_al", seg1, 7'h01);
    check("reen_an_ah", an0, 4'b0001);

    // Reset with data pending and a load in the same cycle.
    lz_en = 1'b0;
    repeat (10) step();
    load = 1'b1; value = 16'h1234; step(); load = 1'b0;
    check("pre_rst_pending", pend0, 1'b1);
    reset = 1'b1; load = 1'b1; value = 16'hABCD; step();
    check("rst_pending", pend0, 1'b0);
    check("rst_an_ah2", an0, 4'h0);
    check("rst_an_al2", an1, 4'hF);
    check("rst_seg_al2", seg1, 7'h7F);
    reset = 1'b0; load = 1'b0;
    step(); step();
    check("post_rst_d0_seg", seg0, 7'h7E);
    wait_digit0();
    check("post_rst_frame_seg", seg0, 7'h7E);
    check("post_rst_pending", pend0, 1'b0);

    // Randomized traffic against the model.
    for (int i = 0; i < 2000; i++) begin
      reset = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 149) == 0) enable = ~enable;
      load  = ($urandom_range(0, 11) == 0);
      value = 16'($urandom) >> (4 * $urandom_range(0, 4));
      dp_in = 4'($urandom);
      if ($urandom_range(0, 99) == 0) lz_en = ~lz_en;
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
